// File: rtl/router_pkg.sv
// Shared types, widths and helpers for the router packet transmitter.
package router_pkg;

  localparam int ADDR_W        = 2;
  localparam int LEN_W         = 6;
  localparam int NUM_PORTS     = 3;
  localparam int PKT_MAX_LEN   = 63;
  localparam int PKT_CHECK_CYC = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_PARITY  = 3'd3,
    ST_CHECK   = 3'd4
  } tx_state_e;

  function automatic logic [LEN_W+ADDR_W-1:0] pack_hdr(
    input logic [LEN_W-1:0]  len,
    input logic [ADDR_W-1:0] addr
  );
    return {len, addr};
  endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Host-side load/launch/status signals and router-side byte stream for router_pkt_tx.
interface router_pkt_tx_if;
  import router_pkg::*;

  logic              wr_en;
  logic [7:0]        wr_data;
  logic              start;
  logic [ADDR_W-1:0] addr;
  logic              busy;
  logic              err;
  logic              pkt_valid;
  logic [7:0]        data_out;
  logic              tx_busy;
  logic              wr_full;
  logic              done;
  logic              err_flag;
  logic              cmd_rej;

  modport master (
    output wr_en, wr_data, start, addr, busy, err,
    input  pkt_valid, data_out, tx_busy, wr_full, done, err_flag, cmd_rej
  );

  modport slave (
    input  wr_en, wr_data, start, addr, busy, err,
    output pkt_valid, data_out, tx_busy, wr_full, done, err_flag, cmd_rej
  );
endinterface

// File: rtl/router_tx_buf.sv
// Payload byte store: one synchronous write port, one combinational read port.
module router_tx_buf #(
  parameter int DEPTH  = 64,
  parameter int DATA_W = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/router_pkt_tx.sv
// Buffers host payload bytes and serialises header, payload and parity toward the router.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int MAX_LEN   = PKT_MAX_LEN,
  parameter int CHECK_CYC = PKT_CHECK_CYC
) (
  input logic            clock,
  input logic            resetn,
  router_pkt_tx_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'(ST_IDLE);
  localparam logic [2:0] S_HEADER  = 3'(ST_HEADER);
  localparam logic [2:0] S_PAYLOAD = 3'(ST_PAYLOAD);
  localparam logic [2:0] S_PARITY  = 3'(ST_PARITY);
  localparam logic [2:0] S_CHECK   = 3'(ST_CHECK);

  localparam int               CNT_W    = (CHECK_CYC > 1) ? $clog2(CHECK_CYC) : 1;
  localparam logic [CNT_W-1:0] CHK_LAST = CNT_W'(CHECK_CYC - 1);
  localparam logic [LEN_W-1:0] FULL_CNT = LEN_W'(MAX_LEN);

  logic [2:0]       r_state;
  logic [LEN_W-1:0] r_count;
  logic [LEN_W-1:0] r_rd_ptr;
  logic [7:0]       r_hdr;
  logic [7:0]       r_parity;
  logic [CNT_W-1:0] r_chk_cnt;
  logic             r_done;
  logic             r_err_flag;
  logic             r_cmd_rej;

  logic             w_idle;
  logic             w_wr_ok;
  logic             w_start_legal;
  logic [LEN_W-1:0] w_len;
  logic [7:0]       w_rd_data;

  assign w_idle        = (r_state == S_IDLE);
  assign w_wr_ok       = w_idle && bus.wr_en && (r_count != FULL_CNT);
  assign w_start_legal = (r_count != '0) && (bus.addr < ADDR_W'(NUM_PORTS));
  assign w_len         = r_hdr[7:2];

  router_tx_buf #(
    .DEPTH  (64),
    .DATA_W (8)
  ) u_buf (
    .clock   (clock),
    .i_we    (w_wr_ok),
    .i_waddr (r_count),
    .i_wdata (bus.wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_hdr      <= '0;
      r_parity   <= '0;
      r_chk_cnt  <= '0;
      r_done     <= 1'b0;
      r_err_flag <= 1'b0;
      r_cmd_rej  <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cmd_rej <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // The header uses the pre-write count, so a same-cycle write is not part of this packet.
          if (w_wr_ok) begin
            r_count <= r_count + LEN_W'(1);
          end
          if (bus.start) begin
            if (w_start_legal) begin
              r_hdr   <= pack_hdr(r_count, bus.addr);
              r_state <= S_HEADER;
            end else begin
              r_cmd_rej <= 1'b1;
            end
          end
        end
        S_HEADER: begin
          if (!bus.busy) begin
            r_parity <= r_hdr;
            r_rd_ptr <= '0;
            r_state  <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (!bus.busy) begin
            r_parity <= r_parity ^ w_rd_data;
            if (r_rd_ptr == w_len - LEN_W'(1)) begin
              r_state <= S_PARITY;
            end else begin
              r_rd_ptr <= r_rd_ptr + LEN_W'(1);
            end
          end
        end
        S_PARITY: begin
          if (!bus.busy) begin
            r_chk_cnt <= '0;
            r_state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (r_chk_cnt == CHK_LAST) begin
            r_err_flag <= bus.err;
            r_done     <= 1'b1;
            r_count    <= '0;
            r_state    <= S_IDLE;
          end else begin
            r_chk_cnt <= r_chk_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Byte outputs decode straight from registered state, so they are stable while busy holds it.
  always_comb begin
    bus.data_out  = 8'h00;
    bus.pkt_valid = 1'b0;
    case (r_state)
      S_HEADER: begin
        bus.data_out  = r_hdr;
        bus.pkt_valid = 1'b1;
      end
      S_PAYLOAD: begin
        bus.data_out  = w_rd_data;
        bus.pkt_valid = 1'b1;
      end
      S_PARITY: begin
        bus.data_out  = r_parity;
        bus.pkt_valid = 1'b0;
      end
      default: begin
        bus.data_out  = 8'h00;
        bus.pkt_valid = 1'b0;
      end
    endcase
  end

  assign bus.tx_busy  = !w_idle;
  assign bus.wr_full  = (r_count == FULL_CNT);
  assign bus.done     = r_done;
  assign bus.err_flag = r_err_flag;
  assign bus.cmd_rej  = r_cmd_rej;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed and randomized checks of router_pkt_tx against a queue-based packet model.
module tb_router_pkt_tx;
  import router_pkg::*;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  router_pkt_tx_if bus ();

  router_pkt_tx dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int           n_tests = 0;
  int           n_fail  = 0;
  byte unsigned model_q[$];
  logic         exp_err_flag = 1'b0;
  logic [7:0]   last_hdr;
  logic [7:0]   last_parity;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input byte unsigned b);
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    tick();
    bus.wr_en = 1'b0;
    if (model_q.size() < 63) model_q.push_back(b);
    chk("wr_full_load", bus.wr_full, model_q.size() == 63);
  endtask

  // busy_mode: 0 = never busy, 1 = random busy plus ignored host traffic, 2 = busy 3 cycles on wire byte 2
  task automatic send_pkt(input logic [1:0] a, input int busy_mode, input logic err_v);
    int           n;
    int           i;
    int           busy_run;
    logic         b;
    logic [7:0]   hdr;
    logic [7:0]   par;
    byte unsigned seq[$];
    n   = model_q.size();
    hdr = {6'(n), a};
    par = hdr;
    seq.push_back(hdr);
    foreach (model_q[k]) begin
      par ^= model_q[k];
      seq.push_back(model_q[k]);
    end
    seq.push_back(par);

    bus.addr  = a;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    i = 0;
    busy_run = 0;
    while (i < seq.size()) begin
      chk("data_out", bus.data_out, seq[i]);
      chk("pkt_valid", bus.pkt_valid, i < seq.size() - 1);
      chk("tx_busy_pkt", bus.tx_busy, 1);
      chk("done_early", bus.done, 0);
      chk("err_flag_hold", bus.err_flag, exp_err_flag);
      chk("wr_full_pkt", bus.wr_full, model_q.size() == 63);
      if (i == 0) last_hdr = bus.data_out;
      if (i == seq.size() - 1) last_parity = bus.data_out;
      b = 1'b0;
      if (busy_mode == 1) b = (busy_run < 3) && ($urandom_range(0, 3) == 0);
      else if (busy_mode == 2) b = (i == 2) && (busy_run < 3);
      busy_run = b ? busy_run + 1 : 0;
      bus.busy = b;
      if (busy_mode == 1) begin
        bus.wr_en   = 1'($urandom_range(0, 1));
        bus.wr_data = 8'($urandom);
        bus.start   = 1'($urandom_range(0, 1));
        bus.addr    = 2'($urandom_range(0, 2));
      end
      tick();
      if (!b) i++;
    end
    bus.busy  = 1'b0;
    bus.wr_en = 1'b0;
    bus.start = 1'b0;
    bus.err   = err_v;
    for (int c = 0; c < PKT_CHECK_CYC; c++) begin
      chk("check_data", bus.data_out, 0);
      chk("check_valid", bus.pkt_valid, 0);
      chk("check_done", bus.done, 0);
      chk("check_tx_busy", bus.tx_busy, 1);
      tick();
    end
    bus.err = 1'b0;
    chk("done", bus.done, 1);
    chk("err_flag", bus.err_flag, err_v);
    chk("tx_busy_end", bus.tx_busy, 0);
    model_q.delete();
    exp_err_flag = err_v;
    tick();
    chk("done_one_cycle", bus.done, 0);
    chk("err_flag_after", bus.err_flag, exp_err_flag);
    chk("wr_full_cleared", bus.wr_full, 0);
    $display("[TB] packet addr=%0d len=%0d hdr=0x%02h parity=0x%02h err=%0b busy_mode=%0d",
             a, n, last_hdr, last_parity, err_v, busy_mode);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = 8'h00;
    bus.start   = 1'b0;
    bus.addr    = 2'd0;
    bus.busy    = 1'b0;
    bus.err     = 1'b0;
    tick();
    tick();
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_pkt_valid", bus.pkt_valid, 0);
    chk("rst_tx_busy", bus.tx_busy, 0);
    chk("rst_wr_full", bus.wr_full, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err_flag", bus.err_flag, 0);
    chk("rst_cmd_rej", bus.cmd_rej, 0);
    resetn = 1'b1;
    tick();

    // Basic three-byte packet to port 2.
    load(8'h11); load(8'h22); load(8'h33);
    send_pkt(2'd2, 0, 1'b0);
    chk("basic_hdr", last_hdr, 8'h0E);
    chk("basic_parity", last_parity, 8'h0E);

    // Same packet with busy held three cycles on 0x22.
    load(8'h11); load(8'h22); load(8'h33);
    send_pkt(2'd2, 2, 1'b0);
    chk("busy_parity", last_parity, 8'h0E);

    // Rejected starts: empty buffer, then illegal address with bytes buffered.
    bus.addr  = 2'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("rej_empty_pulse", bus.cmd_rej, 1);
    chk("rej_empty_idle", bus.tx_busy, 0);
    tick();
    chk("rej_empty_end", bus.cmd_rej, 0);
    load(8'hAA); load(8'h55);
    bus.addr  = 2'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("rej_addr_pulse", bus.cmd_rej, 1);
    chk("rej_addr_idle", bus.tx_busy, 0);
    tick();
    chk("rej_addr_end", bus.cmd_rej, 0);
    send_pkt(2'd1, 0, 1'b0);
    chk("kept_hdr", last_hdr, 8'h09);

    // Fill past capacity: byte 63 is dropped.
    for (int v = 0; v < 64; v++) load(8'(v));
    send_pkt(2'd0, 0, 1'b0);
    chk("full_hdr", last_hdr, 8'hFC);
    chk("full_parity", last_parity, 8'hC3);

    // Router error reported, then cleared by a clean packet.
    load(8'h5A); load(8'hC3);
    send_pkt(2'd1, 0, 1'b1);
    load(8'h01);
    send_pkt(2'd0, 1, 1'b0);

    // Randomized packets.
    for (int p = 0; p < 8; p++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int k = 0; k < len; k++) load(8'($urandom));
      send_pkt(2'($urandom_range(0, 2)), 1, 1'($urandom_range(0, 1)));
    end

    // Leave err_flag set, then reset in the middle of PAYLOAD.
    load(8'h77);
    send_pkt(2'd2, 0, 1'b1);
    load(8'h10); load(8'h20); load(8'h30); load(8'h40);
    bus.addr  = 2'd1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    chk("pre_rst_payload", bus.data_out, 8'h20);
    #2 resetn = 1'b0;
    #1;
    chk("arst_data_out", bus.data_out, 0);
    chk("arst_pkt_valid", bus.pkt_valid, 0);
    chk("arst_tx_busy", bus.tx_busy, 0);
    chk("arst_err_flag", bus.err_flag, 0);
    chk("arst_done", bus.done, 0);
    #3 resetn = 1'b1;
    model_q.delete();
    exp_err_flag = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("post_rst_done", bus.done, 0);
      chk("post_rst_idle", bus.tx_busy, 0);
    end
    chk("post_rst_wr_full", bus.wr_full, 0);
    bus.addr  = 2'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("post_rst_count0", bus.cmd_rej, 1);
    load(8'h3C);
    send_pkt(2'd0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
